wash_phase_timer: RTL
=====================

Name: wash_phase_timer

Overview:
- Timer companion to the washer controller FSM. It consumes the controller's timer-clear strobe R and produces the five phase-done inputs Tf, Tw, Td, Tr and Ts.
- A prescaler divides clk into one-second ticks. A saturating elapsed-seconds counter is compared against five per-phase thresholds.
- It sits beside the controller FSM at the top level and also exports elapsed time for the display.

Parameters:
- CLK_DIV, 50000000, clk cycles per tick; legal range is 1 or more.
- CNT_W, 8, width of the elapsed-seconds counter.
- T_FILL, 10, ticks until Tf asserts.
- T_WASH, 30, ticks until Tw asserts.
- T_DRAIN, 8, ticks until Td asserts.
- T_RINSE, 20, ticks until Tr asserts.
- T_SPIN, 15, ticks until Ts asserts.
- Every threshold must lie in the range 1 to 2^CNT_W-1. Elaboration fails via a generate-time check otherwise.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- R  in  1  synchronous timer clear from the controller; 1 = clear and hold at zero
- Tf  out  1  fill interval elapsed
- Tw  out  1  wash interval elapsed
- Td  out  1  drain interval elapsed
- Tr  out  1  rinse interval elapsed
- Ts  out  1  spin interval elapsed
- tick  out  1  one-cycle pulse on each prescaler wrap
- elapsed  out  CNT_W  seconds since the last clear, saturating

Behaviour:
- Reset (async, active-high): prescaler = 0, elapsed = 0, tick = 0. All T outputs read 0. Reset mid-count discards all progress.
- Prescaler: a register of width clog2(CLK_DIV) (minimum 1 bit).
  - On every rising edge with R=0: if prescaler == CLK_DIV-1, it wraps to 0 and tick is registered to 1; otherwise it increments and tick is registered to 0.
  - With CLK_DIV=1, tick is 1 on every edge where R=0.
- Clear: on any edge with R=1, prescaler, elapsed and tick are all forced to 0. R has priority over a simultaneous wrap.
  - R held high keeps the block frozen at zero indefinitely. This is the hold-state case.
- Elapsed counter: increments on the same edge the prescaler wraps. It saturates at 2^CNT_W-1 and never wraps to 0.
- Done flags: combinational compares on the registered elapsed value.
  - Tf = (elapsed >= T_FILL), Tw = (elapsed >= T_WASH), Td = (elapsed >= T_DRAIN), Tr = (elapsed >= T_RINSE), Ts = (elapsed >= T_SPIN).
  - Flags are levels, not pulses. They stay high until the next clear.
- Latency: counting starts from the first edge at which R=0 after a clear. Flag X rises immediately after the (T_X × CLK_DIV)-th such edge. There are no glitches between edges.
- Since every threshold is at least 1, all flags read 0 in the cycle following a clear.
- Multiple flags may be high at once. The consumer selects whichever flag is relevant to its current state.
- No other state machine: the block is two counters plus compares. There are no back-pressure or handshake signals beyond R.

Decomposition:
- Shared package washer_pkg: the default phase durations (T_FILL, T_WASH, T_DRAIN, T_RINSE, T_SPIN), the default CLK_DIV and CNT_W, and the controller state encodings. This lets the controller and timer agree on values.
- One natural sub-module, tick_gen. It holds the prescaler with parameter CLK_DIV, inputs clk/reset/clr and output tick, and is reusable by the display blink logic.
- wash_phase_timer instantiates tick_gen and holds the elapsed counter and compares.

Test Plan (CLK_DIV=4, CNT_W=4, T_FILL=2, T_WASH=5, T_DRAIN=1, T_RINSE=3, T_SPIN=15):
- Reset then R=0 for 8 edges: tick pulses after edges 4 and 8. elapsed reads 1 then 2. Td=1 after edge 4. Tf=1 after edge 8. Tw, Tr and Ts stay 0.
- Continue with R=0 to edge 20: elapsed = 5. Tw asserts after edge 20. Tf, Td and Tr remain 1.
- Assert R=1 for 1 cycle when elapsed = 3: the next cycle shows elapsed = 0, prescaler = 0 and all flags 0. Recount shows Td rising exactly 4 edges after R falls.
- Hold R=1 for 50 cycles: elapsed = 0, tick = 0 and all flags 0 throughout.
- Run R=0 for 80 edges: elapsed saturates at 15. Ts rises after edge 60 and stays high. elapsed does not wrap to 0.
- Assert async reset mid-prescale at elapsed = 2, prescaler = 3, between clock edges: outputs go to 0 without waiting for a clock edge. After release, the first tick comes 4 edges later.
- R=1 on the same edge as a prescaler wrap: no increment occurs, and elapsed = 0.

Source files
------------

// File: rtl/washer_pkg.sv
// Values shared by the washer controller and its phase timer so both sides
// agree on durations, tick rate and state encodings.
package washer_pkg;

    localparam int DEF_CLK_DIV = 50_000_000;
    localparam int DEF_CNT_W   = 8;

    localparam int DEF_T_FILL  = 10;
    localparam int DEF_T_WASH  = 30;
    localparam int DEF_T_DRAIN = 8;
    localparam int DEF_T_RINSE = 20;
    localparam int DEF_T_SPIN  = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RINSE = 3'd4,
        ST_SPIN  = 3'd5,
        ST_DONE  = 3'd6
    } wash_state_e;

    typedef struct packed {
        logic tf;
        logic tw;
        logic td;
        logic tr;
        logic ts;
    } phase_done_t;

    // Register width needed to count 0..modulus-1, never less than one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/wash_phase_timer_tick_gen.sv
// Prescaler producing a registered one-cycle tick every CLK_DIV clocks,
// with a synchronous clear that restarts the period from zero.
module tick_gen
    import washer_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick,
    output logic wrap
);

    localparam int             PW   = cnt_width(CLK_DIV);
    localparam logic [PW-1:0]  LAST = PW'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("tick_gen: CLK_DIV must be 1 or more");
        end
    endgenerate

    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // High on the edge where the prescaler rolls over; suppressed by clr.
    assign wrap = ~clr & (cnt_q == LAST);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/wash_phase_timer.sv
// Elapsed-seconds counter and phase-done compares feeding the washer
// controller; the controller restarts timing with the R strobe.
module wash_phase_timer
    import washer_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int T_FILL  = DEF_T_FILL,
    parameter int T_WASH  = DEF_T_WASH,
    parameter int T_DRAIN = DEF_T_DRAIN,
    parameter int T_RINSE = DEF_T_RINSE,
    parameter int T_SPIN  = DEF_T_SPIN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             R,
    output logic             Tf,
    output logic             Tw,
    output logic             Td,
    output logic             Tr,
    output logic             Ts,
    output logic             tick,
    output logic [CNT_W-1:0] elapsed
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    generate
        if (T_FILL < 1 || longint'(T_FILL) > CNT_MAX) begin : g_bad_t_fill
            $error("wash_phase_timer: T_FILL out of range");
        end
        if (T_WASH < 1 || longint'(T_WASH) > CNT_MAX) begin : g_bad_t_wash
            $error("wash_phase_timer: T_WASH out of range");
        end
        if (T_DRAIN < 1 || longint'(T_DRAIN) > CNT_MAX) begin : g_bad_t_drain
            $error("wash_phase_timer: T_DRAIN out of range");
        end
        if (T_RINSE < 1 || longint'(T_RINSE) > CNT_MAX) begin : g_bad_t_rinse
            $error("wash_phase_timer: T_RINSE out of range");
        end
        if (T_SPIN < 1 || longint'(T_SPIN) > CNT_MAX) begin : g_bad_t_spin
            $error("wash_phase_timer: T_SPIN out of range");
        end
    endgenerate

    logic wrap;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (R),
        .tick  (tick),
        .wrap  (wrap)
    );

    logic [CNT_W-1:0] elapsed_q, elapsed_d;

    // Counts on the prescaler's rollover edge and sticks at all-ones.
    always_comb begin
        elapsed_d = elapsed_q;
        if (R) begin
            elapsed_d = '0;
        end else if (wrap && (elapsed_q != '1)) begin
            elapsed_d = elapsed_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elapsed_q <= '0;
        end else begin
            elapsed_q <= elapsed_d;
        end
    end

    phase_done_t done;

    always_comb begin
        done.tf = (elapsed_q >= CNT_W'(T_FILL));
        done.tw = (elapsed_q >= CNT_W'(T_WASH));
        done.td = (elapsed_q >= CNT_W'(T_DRAIN));
        done.tr = (elapsed_q >= CNT_W'(T_RINSE));
        done.ts = (elapsed_q >= CNT_W'(T_SPIN));
    end

    assign Tf      = done.tf;
    assign Tw      = done.tw;
    assign Td      = done.td;
    assign Tr      = done.tr;
    assign Ts      = done.ts;
    assign elapsed = elapsed_q;

endmodule
